// File: rtl/image_downsample.sv
// Streaming 2^SHIFT x 2^SHIFT image downsampler (decimate or rounded box average)
// producing a linear {new_y, new_x} address for the next pyramid octave.
module image_downsample #(
  parameter int BIT_DEPTH  = 8,
  parameter int OLD_WIDTH  = 64,
  parameter int OLD_HEIGHT = 64,
  parameter int SHIFT      = 1,
  parameter int MODE       = 1
) (
  input  logic                                                        clk_in,
  input  logic                                                        rst_n_in,
  input  logic [BIT_DEPTH-1:0]                                        data_in,
  input  logic [$clog2(OLD_WIDTH)-1:0]                                data_x_in,
  input  logic [$clog2(OLD_HEIGHT)-1:0]                               data_y_in,
  input  logic                                                        data_valid_in,
  output logic [BIT_DEPTH-1:0]                                        data_out,
  output logic [$clog2(OLD_HEIGHT>>SHIFT)+$clog2(OLD_WIDTH>>SHIFT)-1:0] data_addr_out,
  output logic                                                        data_valid_out,
  output logic                                                        frame_done_out
);

  localparam int NEW_WIDTH  = OLD_WIDTH >> SHIFT;
  localparam int NEW_HEIGHT = OLD_HEIGHT >> SHIFT;
  localparam int XW         = $clog2(NEW_WIDTH);
  localparam int YW         = $clog2(NEW_HEIGHT);
  localparam int OXW        = $clog2(OLD_WIDTH);
  localparam int OYW        = $clog2(OLD_HEIGHT);
  localparam int AW         = BIT_DEPTH + 2 * SHIFT;
  localparam logic [AW-1:0]    ROUND = AW'(1) << (2 * SHIFT - 1);
  localparam logic [SHIFT-1:0] OFS_MAX = '1;

  if (SHIFT < 1 || SHIFT > 3 || (1 << SHIFT) > OLD_WIDTH || (1 << SHIFT) > OLD_HEIGHT) begin : g_bad_shift
    $error("image_downsample: illegal SHIFT=%0d for %0dx%0d frame", SHIFT, OLD_WIDTH, OLD_HEIGHT);
  end

  logic [XW-1:0]        bx_s;
  logic [YW-1:0]        by_s;
  logic [SHIFT-1:0]     ox_s;
  logic [SHIFT-1:0]     oy_s;
  logic                 first_s;
  logic                 last_s;
  logic                 emit_s;
  logic [AW-1:0]        sum_s;
  logic [AW-1:0]        rounded_s;
  logic [BIT_DEPTH-1:0] pix_s;

  logic [AW-1:0]        acc_q [NEW_WIDTH];
  logic [AW-1:0]        acc_d [NEW_WIDTH];
  logic [BIT_DEPTH-1:0] data_q, data_d;
  logic [YW+XW-1:0]     addr_q, addr_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;

  assign bx_s    = data_x_in[OXW-1:SHIFT];
  assign by_s    = data_y_in[OYW-1:SHIFT];
  assign ox_s    = data_x_in[SHIFT-1:0];
  assign oy_s    = data_y_in[SHIFT-1:0];
  assign first_s = (ox_s == '0) && (oy_s == '0);
  assign last_s  = (ox_s == OFS_MAX) && (oy_s == OFS_MAX);

  // A block corner restarts the column sum, so no state leaks across blocks or frames.
  assign sum_s     = (first_s ? {AW{1'b0}} : acc_q[bx_s]) + {{(2 * SHIFT){1'b0}}, data_in};
  assign rounded_s = sum_s + ROUND;
  assign pix_s     = (MODE == 0) ? data_in : rounded_s[AW-1:2*SHIFT];
  assign emit_s    = data_valid_in && ((MODE == 0) ? first_s : last_s);

  // Next-state: accumulator update and output capture on emit.
  always_comb begin
    acc_d   = acc_q;
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (data_valid_in && (MODE == 1)) begin
      acc_d[bx_s] = sum_s;
    end else begin
      acc_d[bx_s] = acc_q[bx_s];
    end
    if (emit_s) begin
      data_d  = pix_s;
      addr_d  = {by_s, bx_s};
      valid_d = 1'b1;
      done_d  = (&bx_s) && (&by_s);
    end else begin
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NEW_WIDTH; i++) begin
        acc_q[i] <= '0;
      end
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign data_out       = data_q;
  assign data_addr_out  = addr_q;
  assign data_valid_out = valid_q;
  assign frame_done_out = done_q;

endmodule

// File: tb/tb_image_downsample.sv
// Directed bench for image_downsample: four parameterisations share one stimulus bus.
module tb_image_downsample;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_s;
  logic [5:0] x_s, y_s;
  logic [3:0] vin;

  logic [7:0] do0, do1, do2, do3;
  logic [3:0] ao0, ao1;
  logic [7:0] ao2;
  logic [1:0] ao3;
  logic       vo0, vo1, vo2, vo3;
  logic       fd0, fd1, fd2, fd3;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] res0 [16];
  logic [7:0] res1 [16];
  logic [7:0] res2 [256];
  logic [7:0] res3 [4];
  int cnt0, cnt1, cnt2, cnt3;
  int dcnt0, dcnt1, dcnt2, dcnt3;
  int daddr0, daddr2;

  always #5 clk = ~clk;

  image_downsample #(.BIT_DEPTH(8), .OLD_WIDTH(8), .OLD_HEIGHT(8), .SHIFT(1), .MODE(1)) u0 (
    .clk_in(clk), .rst_n_in(rst_n), .data_in(data_s), .data_x_in(x_s[2:0]), .data_y_in(y_s[2:0]),
    .data_valid_in(vin[0]), .data_out(do0), .data_addr_out(ao0), .data_valid_out(vo0), .frame_done_out(fd0));
  image_downsample #(.BIT_DEPTH(8), .OLD_WIDTH(8), .OLD_HEIGHT(8), .SHIFT(1), .MODE(0)) u1 (
    .clk_in(clk), .rst_n_in(rst_n), .data_in(data_s), .data_x_in(x_s[2:0]), .data_y_in(y_s[2:0]),
    .data_valid_in(vin[1]), .data_out(do1), .data_addr_out(ao1), .data_valid_out(vo1), .frame_done_out(fd1));
  image_downsample #(.BIT_DEPTH(8), .OLD_WIDTH(64), .OLD_HEIGHT(64), .SHIFT(2), .MODE(1)) u2 (
    .clk_in(clk), .rst_n_in(rst_n), .data_in(data_s), .data_x_in(x_s), .data_y_in(y_s),
    .data_valid_in(vin[2]), .data_out(do2), .data_addr_out(ao2), .data_valid_out(vo2), .frame_done_out(fd2));
  image_downsample #(.BIT_DEPTH(8), .OLD_WIDTH(16), .OLD_HEIGHT(16), .SHIFT(3), .MODE(1)) u3 (
    .clk_in(clk), .rst_n_in(rst_n), .data_in(data_s), .data_x_in(x_s[3:0]), .data_y_in(y_s[3:0]),
    .data_valid_in(vin[3]), .data_out(do3), .data_addr_out(ao3), .data_valid_out(vo3), .frame_done_out(fd3));

  // Capture every output strobe into per-DUT address-indexed tables.
  always @(negedge clk) begin
    if (vo0) begin res0[ao0] = do0; cnt0++; if (fd0) begin dcnt0++; daddr0 = int'(ao0); end end
    if (vo1) begin res1[ao1] = do1; cnt1++; if (fd1) dcnt1++; end
    if (vo2) begin res2[ao2] = do2; cnt2++; if (fd2) begin dcnt2++; daddr2 = int'(ao2); end end
    if (vo3) begin res3[ao3] = do3; cnt3++; if (fd3) dcnt3++; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 16; i++) begin res0[i] = 'x; res1[i] = 'x; end
    for (int i = 0; i < 256; i++) res2[i] = 'x;
    for (int i = 0; i < 4; i++) res3[i] = 'x;
    cnt0 = 0; cnt1 = 0; cnt2 = 0; cnt3 = 0;
    dcnt0 = 0; dcnt1 = 0; dcnt2 = 0; dcnt3 = 0;
    daddr0 = -1; daddr2 = -1;
  endtask

  task automatic feed(input int x, input int y, input int pix, input int sel);
    bit corner;
    data_s = pix[7:0];
    x_s = x[5:0];
    y_s = y[5:0];
    vin = 4'b0000;
    vin[sel] = 1'b1;
    @(posedge clk);
    #1;
    vin = 4'b0000;
    corner = ((x % 2) == 0) && ((y % 2) == 0);
    if (sel == 1) begin
      chk("m0_strobe", {31'b0, vo1}, {31'b0, corner});
      if (corner) begin
        chk("m0_data", {24'b0, do1}, x + y);
        chk("m0_addr", {28'b0, ao1}, (y / 2) * 4 + x / 2);
      end
    end
    if (sel == 2) begin
      @(posedge clk);
      #1;
    end
  endtask

  // cval < 0 selects the pixel = x + y ramp.
  task automatic frame(input int w, input int h, input int sel, input int cval);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        feed(x, y, (cval < 0) ? x + y : cval, sel);
  endtask

  task automatic check_avg8(input string tag);
    chk({tag, "_count"}, cnt0, 16);
    chk({tag, "_done_count"}, dcnt0, 1);
    chk({tag, "_done_addr"}, daddr0, 15);
    chk({tag, "_addr0"}, {24'b0, res0[0]}, 1);
    chk({tag, "_addr1"}, {24'b0, res0[1]}, 3);
    for (int by = 0; by < 4; by++)
      for (int bx = 0; bx < 4; bx++)
        chk({tag, "_pix"}, {24'b0, res0[by * 4 + bx]}, 2 * bx + 2 * by + 1);
  endtask

  initial begin
    rst_n = 1'b0;
    data_s = 8'd0; x_s = 6'd0; y_s = 6'd0; vin = 4'b0000;
    clr();
    #3;
    chk("rst_data", {24'b0, do0}, 0);
    chk("rst_addr", {28'b0, ao0}, 0);
    chk("rst_valid", {31'b0, vo0}, 0);
    chk("rst_done", {31'b0, fd0}, 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // 8x8 box average on the x+y ramp
    clr();
    frame(8, 8, 0, -1);
    repeat (2) @(posedge clk); #1;
    check_avg8("avg8");

    // 8x8 decimation with per-pixel latency checks
    clr();
    frame(8, 8, 1, -1);
    repeat (2) @(posedge clk); #1;
    chk("dec_count", cnt1, 16);
    chk("dec_addr0", {24'b0, res1[0]}, 0);
    chk("dec_addr1", {24'b0, res1[1]}, 2);
    chk("dec_addr4", {24'b0, res1[4]}, 2);

    // 64x64 SHIFT=2 average, valid every other cycle
    clr();
    frame(64, 64, 2, -1);
    repeat (2) @(posedge clk); #1;
    chk("avg64_count", cnt2, 256);
    chk("avg64_done_count", dcnt2, 1);
    chk("avg64_done_addr", daddr2, 255);
    chk("avg64_addr0", {24'b0, res2[0]}, 3);
    chk("avg64_addr17", {24'b0, res2[17]}, 11);
    for (int by = 0; by < 16; by++)
      for (int bx = 0; bx < 16; bx++)
        chk("avg64_pix", {24'b0, res2[by * 16 + bx]}, 4 * (bx + by) + 3);

    // SHIFT=3 saturation-free extremes
    clr();
    frame(16, 16, 3, 255);
    repeat (2) @(posedge clk); #1;
    chk("s3_max_count", cnt3, 4);
    chk("s3_max_done", dcnt3, 1);
    for (int i = 0; i < 4; i++) chk("s3_max_pix", {24'b0, res3[i]}, 255);
    clr();
    frame(16, 16, 3, 1);
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) chk("s3_one_pix", {24'b0, res3[i]}, 1);

    // asynchronous reset mid-row, then a clean restart
    clr();
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 8; x++)
        if (y == 0 || x < 4) feed(x, y, x + y, 0);
    chk("pre_rst_data", {24'b0, do0}, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", {24'b0, do0}, 0);
    chk("async_rst_addr", {28'b0, ao0}, 0);
    chk("async_rst_valid", {31'b0, vo0}, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    clr();
    frame(8, 8, 0, -1);
    repeat (2) @(posedge clk); #1;
    check_avg8("restart");

    // back-to-back frames with no gap
    clr();
    frame(8, 8, 0, 10);
    frame(8, 8, 0, 200);
    repeat (2) @(posedge clk); #1;
    chk("b2b_count", cnt0, 32);
    chk("b2b_done_count", dcnt0, 2);
    for (int i = 0; i < 16; i++) chk("b2b_pix", {24'b0, res0[i]}, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
